// File: rtl/frame_output_buffer_pkg.sv
// Shared constants for the convolution result path: pixel/word widths and FSM encoding.
package conv_pkg;
  localparam int NB_PIXEL     = 8;
  localparam int NB_INST      = 32;
  localparam int PIX_PER_WORD = NB_INST / NB_PIXEL;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    PREFETCH = 2'd2,
    READY    = 2'd3
  } state_e;
endpackage

// File: rtl/frame_output_buffer_if.sv
// Pixel-in / micro-out bundle of frame_output_buffer; o_state is a debug view of the FSM.
// Handshake: i_pixel is taken on any clock edge where i_pixel_valid=1 (no backpressure);
// i_get_pixels is a one-cycle pulse acknowledging the word on o_pixels_to_micro.
interface frame_output_buffer_if import conv_pkg::*; ();
  logic                i_start_conv;
  logic [NB_PIXEL-1:0] i_pixel;
  logic                i_pixel_valid;
  logic                i_get_pixels;
  logic [NB_INST-1:0]  o_pixels_to_micro;
  logic                o_frame_ready;
  logic                o_overflow;
  state_e              o_state;

  modport master (
    output i_start_conv, i_pixel, i_pixel_valid, i_get_pixels,
    input  o_pixels_to_micro, o_frame_ready, o_overflow, o_state
  );

  modport slave (
    input  i_start_conv, i_pixel, i_pixel_valid, i_get_pixels,
    output o_pixels_to_micro, o_frame_ready, o_overflow, o_state
  );
endinterface

// File: rtl/frame_output_buffer_ram.sv
// Frame word store: one write port, one registered read port; only the read register resets.
module frame_ram import conv_pkg::*; #(
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [NB_INST-1:0] wdata_i,
  input  logic               re_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [NB_INST-1:0] rdata_o
);
  logic [NB_INST-1:0] mem_q [2**NB_ADDR];
  logic [NB_INST-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register only moves on a read, so it holds the last served word.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_output_buffer.sv
// Packs convolved pixels four per word into frame_ram and serves them to the micro one word
// per get pulse. Optional sticky misuse flag built only with FRAME_OUT_OVERFLOW_EN defined.
module frame_output_buffer import conv_pkg::*; #(
  parameter int FRAME_PIXELS = 1024,
  parameter int NB_ADDR      = 8
) (
  input logic                  clock,
  input logic                  reset,
  frame_output_buffer_if.slave bus
);
  localparam int NB_CNT  = $clog2(FRAME_PIXELS) + 1;
  localparam int LANE_W  = $clog2(PIX_PER_WORD);
  localparam int N_WORDS = FRAME_PIXELS / PIX_PER_WORD;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);
  localparam logic [NB_CNT-1:0]  LAST_PIX  = NB_CNT'(FRAME_PIXELS - 1);

  if (FRAME_PIXELS % PIX_PER_WORD != 0) begin : g_bad_frame
    $error("FRAME_PIXELS must be a multiple of PIX_PER_WORD");
  end
  if ((2 ** NB_ADDR) < N_WORDS) begin : g_bad_addr
    $error("NB_ADDR too small to hold one frame");
  end

  state_e              state_q;
  logic [NB_CNT-1:0]   pix_cnt_q;
  logic [NB_INST-1:0]  pack_q, pack_d;
  logic [NB_ADDR-1:0]  wr_addr_q, rd_addr_q;
  logic                rd_pend_q, frame_ready_q;
  logic                fill_pix, word_full, ram_we, ram_re;

  assign fill_pix  = (state_q == FILL) && bus.i_pixel_valid && !bus.i_start_conv;
  assign word_full = (pix_cnt_q[LANE_W-1:0] == LANE_W'(PIX_PER_WORD - 1));
  assign pack_d    = {pack_q[NB_INST-NB_PIXEL-1:0], bus.i_pixel};
  assign ram_we    = fill_pix && word_full;
  // rd_addr_q is 0 in PREFETCH, so one read port serves both the prefetch and later gets.
  assign ram_re    = !bus.i_start_conv && ((state_q == PREFETCH) || rd_pend_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      pack_q        <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      frame_ready_q <= 1'b0;
    end else if (bus.i_start_conv) begin
      state_q       <= FILL;
      pix_cnt_q     <= '0;
      pack_q        <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      rd_pend_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= IDLE;
        FILL: begin
          if (bus.i_pixel_valid) begin
            pack_q    <= pack_d;
            pix_cnt_q <= pix_cnt_q + NB_CNT'(1);
            if (word_full)             wr_addr_q <= wr_addr_q + NB_ADDR'(1);
            if (pix_cnt_q == LAST_PIX) state_q   <= PREFETCH;
          end
        end
        PREFETCH: begin
          state_q       <= READY;
          frame_ready_q <= 1'b1;
        end
        READY: begin
          if (bus.i_get_pixels) begin
            if (rd_addr_q == LAST_ADDR) begin
              state_q       <= IDLE;
              frame_ready_q <= 1'b0;
            end else begin
              rd_addr_q <= rd_addr_q + NB_ADDR'(1);
              rd_pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  frame_ram #(.NB_ADDR(NB_ADDR)) u_ram (
    .clk     (clock),
    .rst     (reset),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (pack_d),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdata_o (bus.o_pixels_to_micro)
  );

`ifdef FRAME_OUT_OVERFLOW_EN
  logic overflow_q;
  always_ff @(posedge clock) begin
    if (reset || bus.i_start_conv) begin
      overflow_q <= 1'b0;
    end else if ((bus.i_pixel_valid && state_q != FILL) ||
                 (bus.i_get_pixels && state_q != READY)) begin
      overflow_q <= 1'b1;
    end
  end
  assign bus.o_overflow = overflow_q;
`else
  assign bus.o_overflow = 1'b0;
`endif

  assign bus.o_frame_ready = frame_ready_q;
  assign bus.o_state       = state_q;
endmodule

// File: tb/tb_frame_output_buffer.sv
// Directed + randomized bench for frame_output_buffer with a 16-pixel frame.
module tb_frame_output_buffer;
  import conv_pkg::*;

  localparam int FRAME_PIXELS = 16;
  localparam int N_WORDS      = FRAME_PIXELS / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0]  px_q[$];
  logic [31:0] exp_q[$];

  frame_output_buffer_if bus ();

  frame_output_buffer #(.FRAME_PIXELS(FRAME_PIXELS), .NB_ADDR(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is just its pixel list, big-endian packed four per word.
  task automatic build_words();
    exp_q.delete();
    for (int w = 0; w < N_WORDS; w++)
      exp_q.push_back({px_q[4*w], px_q[4*w+1], px_q[4*w+2], px_q[4*w+3]});
  endtask

  task automatic idle_inputs();
    bus.i_start_conv  = 1'b0;
    bus.i_pixel       = '0;
    bus.i_pixel_valid = 1'b0;
    bus.i_get_pixels  = 1'b0;
  endtask

  task automatic start_pulse();
    bus.i_start_conv = 1'b1;
    @(negedge clk);
    bus.i_start_conv = 1'b0;
  endtask

  task automatic fill_random(input int lo, input int hi);
    px_q.delete();
    for (int i = 0; i < FRAME_PIXELS; i++) px_q.push_back(8'($urandom_range(hi, lo)));
  endtask

  // Feeds px_q with gaps of gap_lo..gap_hi idle cycles, then checks frame-ready timing.
  task automatic run_frame(input int gap_lo, input int gap_hi);
    int gap;
    build_words();
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      bus.i_pixel       = px_q[i];
      bus.i_pixel_valid = 1'b1;
      @(negedge clk);
      bus.i_pixel_valid = 1'b0;
      bus.i_pixel       = 8'($urandom);
      if (i != FRAME_PIXELS - 1) begin
        chk("ready_early", 32'(bus.o_frame_ready), 32'd0);
        gap = $urandom_range(gap_hi, gap_lo);
        repeat (gap) @(negedge clk);
      end
    end
    chk("ready_prefetch", 32'(bus.o_frame_ready), 32'd0);
    chk("state_prefetch", 32'(bus.o_state), 32'(PREFETCH));
    @(negedge clk);
    chk("ready_rise", 32'(bus.o_frame_ready), 32'd1);
    chk("word0", bus.o_pixels_to_micro, exp_q[0]);
    chk("state_ready", 32'(bus.o_state), 32'(READY));
  endtask

  // Four get pulses spaced 4 cycles; junk=1 also drives stray pixels that must be dropped.
  task automatic drain(input bit junk);
    for (int w = 1; w <= N_WORDS; w++) begin
      bus.i_get_pixels = 1'b1;
      @(negedge clk);
      bus.i_get_pixels = 1'b0;
      if (w < N_WORDS) begin
        chk("word_hold", bus.o_pixels_to_micro, exp_q[w-1]);
        @(negedge clk);
        chk("word_next", bus.o_pixels_to_micro, exp_q[w]);
        chk("ready_hold", 32'(bus.o_frame_ready), 32'd1);
        bus.i_pixel_valid = junk;
        bus.i_pixel       = 8'($urandom);
        @(negedge clk);
        bus.i_pixel_valid = 1'b0;
        @(negedge clk);
      end else begin
        chk("ready_fall", 32'(bus.o_frame_ready), 32'd0);
        chk("state_idle", 32'(bus.o_state), 32'(IDLE));
        chk("last_hold", bus.o_pixels_to_micro, exp_q[N_WORDS-1]);
        @(negedge clk);
        chk("last_hold2", bus.o_pixels_to_micro, exp_q[N_WORDS-1]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_word", bus.o_pixels_to_micro, 32'd0);
    chk("rst_ready", 32'(bus.o_frame_ready), 32'd0);
    chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
    chk("rst_state", 32'(bus.o_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back pixels 0x01..0x10, then drain.
    start_pulse();
    px_q.delete();
    for (int i = 1; i <= FRAME_PIXELS; i++) px_q.push_back(8'(i));
    run_frame(0, 0);
    chk("t1_word0", bus.o_pixels_to_micro, 32'h0102_0304);
    drain(1'b0);
    chk("t2_last", bus.o_pixels_to_micro, 32'h0D0E_0F10);

    // Same data, valid every 3rd cycle.
    start_pulse();
    run_frame(2, 2);
    drain(1'b1);

    // Abort after 6 pixels, restart with 0xA0..0xAF.
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      bus.i_pixel = 8'($urandom); bus.i_pixel_valid = 1'b1;
      @(negedge clk);
    end
    bus.i_pixel_valid = 1'b0;
    start_pulse();
    chk("abort_state", 32'(bus.o_state), 32'(FILL));
    px_q.delete();
    for (int i = 0; i < FRAME_PIXELS; i++) px_q.push_back(8'(8'hA0 + i));
    run_frame(0, 1);
    chk("t4_word0", bus.o_pixels_to_micro, 32'hA0A1_A2A3);
    drain(1'b0);

    // Start and a 0xFF pixel together: the pixel must not enter the frame.
    bus.i_start_conv = 1'b1; bus.i_pixel = 8'hFF; bus.i_pixel_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    fill_random(0, 254);
    run_frame(0, 2);
    drain(1'b0);

    // Stray get while filling is ignored; abort from READY drops frame-ready next cycle.
    start_pulse();
    bus.i_get_pixels = 1'b1;
    @(negedge clk);
    bus.i_get_pixels = 1'b0;
    chk("get_in_fill", 32'(bus.o_state), 32'(FILL));
    fill_random(0, 255);
    run_frame(0, 3);
    start_pulse();
    chk("abort_ready", 32'(bus.o_frame_ready), 32'd0);
    chk("abort_ready_st", 32'(bus.o_state), 32'(FILL));

    // Randomized frames.
    for (int f = 0; f < 3; f++) begin
      start_pulse();
      fill_random(0, 255);
      run_frame(0, 3);
      drain(f[0]);
    end

    // Misuse flag: stray pixel in IDLE, cleared by start, set again by get outside READY.
    bus.i_pixel = 8'h55; bus.i_pixel_valid = 1'b1;
    @(negedge clk);
    bus.i_pixel_valid = 1'b0;
`ifdef FRAME_OUT_OVERFLOW_EN
    chk("ovf_set", 32'(bus.o_overflow), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    start_pulse();
    chk("ovf_clear", 32'(bus.o_overflow), 32'd0);
    bus.i_get_pixels = 1'b1;
    @(negedge clk);
    bus.i_get_pixels = 1'b0;
    chk("ovf_get", 32'(bus.o_overflow), 32'd1);
`else
    chk("ovf_off", 32'(bus.o_overflow), 32'd0);
    repeat (3) @(negedge clk);
    chk("ovf_off2", 32'(bus.o_overflow), 32'd0);
    start_pulse();
    chk("ovf_off3", 32'(bus.o_overflow), 32'd0);
`endif

    // Reset in the middle of a fill.
    for (int i = 0; i < 5; i++) begin
      bus.i_pixel = 8'($urandom); bus.i_pixel_valid = 1'b1;
      @(negedge clk);
    end
    bus.i_pixel_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(bus.o_state), 32'(IDLE));
    chk("mid_rst_word", bus.o_pixels_to_micro, 32'd0);
    chk("mid_rst_ready", 32'(bus.o_frame_ready), 32'd0);
    chk("mid_rst_ovf", 32'(bus.o_overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A full frame after the reset still packs correctly from word 0.
    start_pulse();
    fill_random(0, 255);
    run_frame(0, 1);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
